// File: rtl/spi_sram_target.sv
// spi_sram_target: SPI mode-0 target that emulates a serial SRAM.
// Supports READ (0x03) and WRITE (0x02) with a 24-bit address in sequential
// (auto-increment, wrapping) mode, backed by a 2**ADDR_WIDTH byte array.
// sck/cs_n/mosi are oversampled on clk_i. MISO changes only on sck falls.
// Optional macro SPI_TARGET_SYNC_EN: adds a 2-flop synchroniser on each SPI
// input for initiators asynchronous to clk_i (sck period >= 8 clk_i).
// ADDR_WIDTH is expected to be at most 24.
module spi_sram_target #(
  parameter int ADDR_WIDTH  = 10,
  parameter int SCK_MIN_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sck_i,
  input  logic cs_ni,
  input  logic mosi_i,
  output logic miso_o,
  output logic miso_oe_o,
  output logic busy_o,
  output logic cmd_err_o
);

  localparam int DEPTH    = 1 << ADDR_WIDTH;
  localparam int EDGE_GAP = SCK_MIN_DIV / 2;
  // Shift register keeps every bit needed to form the address or a byte.
  localparam int SH_W     = ((ADDR_WIDTH > 8) ? ADDR_WIDTH : 8) - 1;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR_RD,
    ADDR_WR,
    READ,
    WRITE,
    IGNORE
  } state_e;

  // Sampled SPI inputs and edge detection
  logic sck_q, cs_q, mosi_q, sck_prev_q;
  logic rise, fall;

  // Protocol state
  state_e                  state_q;
  logic [4:0]              cnt_q;
  logic [SH_W-1:0]         sh_q;
  logic [SH_W:0]           sh_d;
  logic [7:0]              tx_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH-1:0]   addr_inc;
  logic                    miso_q, oe_q, busy_q, err_q;

  // Memory ports
  logic                    wr_en_q;
  logic [ADDR_WIDTH-1:0]   wr_addr_q;
  logic [7:0]              wr_data_q;
  logic [7:0]              rd_data_q;
  logic [7:0]              mem_q [DEPTH];

  // Edge spacing monitor
  logic [3:0]              gap_q;

`ifdef SPI_TARGET_SYNC_EN
  logic sck_meta_q, cs_meta_q, mosi_meta_q, sck_sync_q, cs_sync_q, mosi_sync_q;

  // Two-flop synchronisers, then the common input register stage
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sck_meta_q  <= 1'b0;
      cs_meta_q   <= 1'b1;
      mosi_meta_q <= 1'b0;
      sck_sync_q  <= 1'b0;
      cs_sync_q   <= 1'b1;
      mosi_sync_q <= 1'b0;
      sck_q       <= 1'b0;
      cs_q        <= 1'b1;
      mosi_q      <= 1'b0;
    end else begin
      sck_meta_q  <= sck_i;
      cs_meta_q   <= cs_ni;
      mosi_meta_q <= mosi_i;
      sck_sync_q  <= sck_meta_q;
      cs_sync_q   <= cs_meta_q;
      mosi_sync_q <= mosi_meta_q;
      sck_q       <= sck_sync_q;
      cs_q        <= cs_sync_q;
      mosi_q      <= mosi_sync_q;
    end
  end
`else
  // Single input register stage; initiator shares clk_i
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sck_q  <= 1'b0;
      cs_q   <= 1'b1;
      mosi_q <= 1'b0;
    end else begin
      sck_q  <= sck_i;
      cs_q   <= cs_ni;
      mosi_q <= mosi_i;
    end
  end
`endif

  // Previous sck sample; tracks sck continuously so an sck already high at
  // CS assertion never looks like a rising edge
  always_ff @(posedge clk_i) begin
    if (!rst_ni) sck_prev_q <= 1'b0;
    else         sck_prev_q <= sck_q;
  end

  // Edges only count while selected, so CS deassert beats a coincident edge
  assign rise     = sck_q & ~sck_prev_q & ~cs_q;
  assign fall     = ~sck_q & sck_prev_q & ~cs_q;
  assign sh_d     = {sh_q, mosi_q};
  assign addr_inc = addr_q + 1'b1;

  // Protocol FSM with registered outputs
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      tx_q      <= '0;
      addr_q    <= '0;
      miso_q    <= 1'b0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      err_q   <= 1'b0;
      wr_en_q <= 1'b0;
      if (cs_q) begin
        // Deselect aborts everything; partial bytes are dropped
        state_q <= IDLE;
        cnt_q   <= '0;
        sh_q    <= '0;
        oe_q    <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= CMD;
            cnt_q   <= '0;
            sh_q    <= '0;
            busy_q  <= 1'b1;
          end
          CMD: begin
            if (rise) begin
              sh_q  <= sh_d[SH_W-1:0];
              cnt_q <= cnt_q + 5'd1;
              if (cnt_q == 5'd7) begin
                cnt_q <= '0;
                if (sh_d[7:0] == 8'h03) begin
                  state_q <= ADDR_RD;
                end else if (sh_d[7:0] == 8'h02) begin
                  state_q <= ADDR_WR;
                end else begin
                  state_q <= IGNORE;
                  err_q   <= 1'b1;
                end
              end
            end
          end
          ADDR_RD, ADDR_WR: begin
            if (rise) begin
              sh_q  <= sh_d[SH_W-1:0];
              cnt_q <= cnt_q + 5'd1;
              if (cnt_q == 5'd23) begin
                // Upper address bits fall off the shift register
                cnt_q   <= '0;
                addr_q  <= sh_d[ADDR_WIDTH-1:0];
                state_q <= (state_q == ADDR_RD) ? READ : WRITE;
              end
            end
          end
          READ: begin
            if (fall) begin
              oe_q  <= 1'b1;
              cnt_q <= cnt_q + 5'd1;
              if (cnt_q == 5'd0) begin
                // Byte boundary: rd_data_q already holds mem[addr_q]
                miso_q <= rd_data_q[7];
                tx_q   <= {rd_data_q[6:0], 1'b0};
              end else begin
                miso_q <= tx_q[7];
                tx_q   <= {tx_q[6:0], 1'b0};
              end
              if (cnt_q == 5'd7) begin
                cnt_q  <= '0;
                addr_q <= addr_inc;
              end
            end
          end
          WRITE: begin
            if (rise) begin
              sh_q  <= sh_d[SH_W-1:0];
              cnt_q <= cnt_q + 5'd1;
              if (cnt_q == 5'd7) begin
                cnt_q     <= '0;
                wr_en_q   <= 1'b1;
                wr_addr_q <= addr_q;
                wr_data_q <= sh_d[7:0];
                addr_q    <= addr_inc;
              end
            end
          end
          IGNORE: begin
            oe_q <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  // Byte array: one-cycle write, registered read of the current address
  always_ff @(posedge clk_i) begin
    if (wr_en_q) mem_q[wr_addr_q] <= wr_data_q;
    rd_data_q <= mem_q[addr_q];
  end

  // Each sck phase must leave time for the registered read before the next edge
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      gap_q <= '1;
    end else begin
      if (rise || fall) begin
        assert (int'(gap_q) + 1 >= EDGE_GAP);
        gap_q <= '0;
      end else if (gap_q != '1) begin
        gap_q <= gap_q + 4'd1;
      end
    end
  end

  assign miso_o    = miso_q;
  assign miso_oe_o = oe_q;
  assign busy_o    = busy_q;
  assign cmd_err_o = err_q;

endmodule

// File: tb/tb_spi_sram_target.sv
// Bench for spi_sram_target: drives SPI mode-0 transactions and compares
// read-back data against a byte-array memory model kept here.
module tb_spi_sram_target;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
  localparam int HALF  = 4;
`ifdef SPI_TARGET_SYNC_EN
  localparam int BUSY_BOUND = 5;
`else
  localparam int BUSY_BOUND = 3;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sck   = 1'b0;
  logic cs_n  = 1'b1;
  logic mosi  = 1'b0;
  logic miso, miso_oe, busy, cmd_err;

  int nvec = 0;
  int nerr = 0;
  int err_cycles = 0;
  int oe_cycles  = 0;

  logic [7:0]  ref_mem [DEPTH];
  logic [7:0]  wbuf [8];
  logic [23:0] raddr [6];
  int          rlen [6];

  spi_sram_target #(.ADDR_WIDTH(AW), .SCK_MIN_DIV(4)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .sck_i    (sck),
    .cs_ni    (cs_n),
    .mosi_i   (mosi),
    .miso_o   (miso),
    .miso_oe_o(miso_oe),
    .busy_o   (busy),
    .cmd_err_o(cmd_err)
  );

  always #5 clk = ~clk;

  // Count cycles with cmd_err / oe high, sampled just after each clock edge
  always @(posedge clk) begin
    #1;
    if (cmd_err === 1'b1) err_cycles++;
    if (miso_oe === 1'b1) oe_cycles++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Shift the top nbits of tx MSB-first; miso is captured just before each rise
  task automatic spi_byte(input logic [7:0] tx, input int nbits, input logic exp_oe,
                          output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = tx[i];
      repeat (HALF) @(negedge clk);
      rx[i] = miso;
      chk("miso_oe", 32'(miso_oe), 32'(exp_oe));
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic start_cmd(input logic [7:0] cmd, input logic [23:0] addr);
    logic [7:0] rx;
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    chk("busy_rise", 32'(busy), 32'd1);
    spi_byte(cmd, 8, 1'b0, rx);
    spi_byte(addr[23:16], 8, 1'b0, rx);
    spi_byte(addr[15:8], 8, 1'b0, rx);
    spi_byte(addr[7:0], 8, 1'b0, rx);
  endtask

  task automatic end_txn();
    int n;
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    n = 0;
    while (busy !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("busy_fall", 32'(n <= BUSY_BOUND), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  // Write wbuf[0..n-1] from addr; model keeps low AW bits, wraps sequentially
  task automatic do_write(input logic [23:0] addr, input int n);
    logic [7:0] rx;
    start_cmd(8'h02, addr);
    for (int k = 0; k < n; k++) begin
      spi_byte(wbuf[k], 8, 1'b0, rx);
      ref_mem[(int'(addr) + k) % DEPTH] = wbuf[k];
    end
    end_txn();
  endtask

  task automatic do_read(input logic [23:0] addr, input int n, input string tag);
    logic [7:0] rx;
    start_cmd(8'h03, addr);
    for (int k = 0; k < n; k++) begin
      spi_byte(8'h00, 8, 1'b1, rx);
      chk(tag, 32'(rx), 32'(ref_mem[(int'(addr) + k) % DEPTH]));
    end
    end_txn();
  endtask

  initial begin
    int e0;
    int o0;
    logic [7:0] rx;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_oe", 32'(miso_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(cmd_err), 32'd0);
    chk("rst_miso", 32'(miso), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single write then read-back
    e0 = err_cycles;
    wbuf[0] = 8'hA5;
    do_write(24'h000010, 1);
    chk("wr_no_err", 32'(err_cycles - e0), 32'd0);
    o0 = oe_cycles;
    do_read(24'h000010, 1, "rd_a5");
    chk("rd_oe_active", 32'(oe_cycles > o0), 32'd1);

    // Sequential burst across the top of memory
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    do_write(24'h0003FE, 3);
    do_read(24'h0003FE, 3, "rd_burst");
    do_read(24'h000000, 1, "rd_wrap0");

    // Unsupported command
    e0 = err_cycles;
    o0 = oe_cycles;
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_byte(8'h9F, 8, 1'b0, rx);
    chk("err_pulse", 32'(err_cycles - e0), 32'd1);
    spi_byte(8'h00, 8, 1'b0, rx);
    spi_byte(8'h00, 8, 1'b0, rx);
    spi_byte(8'h10, 8, 1'b0, rx);
    spi_byte(8'hFF, 8, 1'b0, rx);
    end_txn();
    chk("err_single", 32'(err_cycles - e0), 32'd1);
    chk("err_no_oe", 32'(oe_cycles - o0), 32'd0);
    do_read(24'h000010, 1, "rd_after_err");

    // Aborted writes leave memory unchanged
    wbuf[0] = 8'h5A; wbuf[1] = 8'h3C;
    do_write(24'h000020, 2);
    start_cmd(8'h02, 24'h000020);
    spi_byte(8'hFF, 5, 1'b0, rx);
    end_txn();
    do_read(24'h000020, 1, "rd_abort5");

    // CS deassert coincident with the 8th data rise
    start_cmd(8'h02, 24'h000021);
    spi_byte(8'hC3, 7, 1'b0, rx);
    mosi = 1'b1;
    repeat (HALF) @(negedge clk);
    sck  = 1'b1;
    cs_n = 1'b1;
    repeat (HALF) @(negedge clk);
    sck = 1'b0;
    repeat (6) @(negedge clk);
    chk("busy_after_race", 32'(busy), 32'd0);
    do_read(24'h000020, 2, "rd_race");

    // Reset in the middle of a read burst; memory must survive
    start_cmd(8'h03, 24'h0003FE);
    spi_byte(8'h00, 8, 1'b1, rx);
    chk("rd_pre_rst", 32'(rx), 32'(ref_mem[10'h3FE]));
    spi_byte(8'h00, 3, 1'b1, rx);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_oe", 32'(miso_oe), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    cs_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    do_read(24'h000010, 1, "rd_after_rst");

    // Randomised bursts with random upper address bits
    for (int t = 0; t < 6; t++) begin
      raddr[t] = 24'($urandom);
      rlen[t]  = $urandom_range(1, 4);
      for (int k = 0; k < rlen[t]; k++) wbuf[k] = 8'($urandom);
      do_write(raddr[t], rlen[t]);
      do_read(raddr[t], rlen[t], "rand_rd");
    end
    for (int t = 0; t < 6; t++) do_read(raddr[t], rlen[t], "rand_reread");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/spi_sram_target.md
Name: spi_sram_target

Overview:
- SPI mode-0 target that emulates a serial SRAM (READ 0x03 / WRITE 0x02, 24-bit address, sequential mode) backed by an internal byte array.
- It is the far end of the team's SPI SRAM initiator: used as an on-chip/FPGA stand-in memory and as the bench responder for initiator verification.
- Runs on its own system clock and oversamples sck/cs_n/mosi.

Parameters:
- ADDR_WIDTH, 10, number of implemented address bits; memory is 2**ADDR_WIDTH bytes, upper address bits ignored.
- SCK_MIN_DIV, 4, documented minimum clk_i cycles per sck period (8 when SPI_TARGET_SYNC_EN); no RTL effect beyond an assertion.

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  synchronous reset, active low
- sck_i  input  1  SPI clock from initiator
- cs_ni  input  1  chip select, active low
- mosi_i  input  1  serial data in (initiator sio_out[0])
- miso_o  output  1  serial data out (initiator sio_in[1])
- miso_oe_o  output  1  high while driving miso_o
- busy_o  output  1  high from CS assert until return to IDLE
- cmd_err_o  output  1  one-cycle pulse when an unsupported command byte completes

Behaviour:
- Reset (rst_ni low at a clk_i edge): state IDLE, miso_o=0, miso_oe_o=0, busy_o=0, cmd_err_o=0, bit counter=0, shift registers=0. Memory contents are not reset.
- Interface timing:
  - Internal sck_q/cs_q/mosi_q are the (optionally synchronised) inputs; sck_prev is a register of sck_q.
  - rise = sck_q & !sck_prev; fall = !sck_q & sck_prev.
  - mosi is sampled on rise; miso changes only on fall.
- cs_q high: state goes to IDLE on the next clk edge from any state. miso_oe_o=0, busy_o=0, partial bytes discarded. A read or write never completes partially.
- States:
  - IDLE: on cs_q low → CMD, counter=0, busy_o=1.
  - CMD: shift 8 bits MSB-first on rise. After the 8th rise: 0x03 → ADDR_RD; 0x02 → ADDR_WR; any other → IGNORE and pulse cmd_err_o for 1 cycle.
  - ADDR_RD / ADDR_WR: shift 24 bits MSB-first; addr = low ADDR_WIDTH bits.
    - After the 24th rise, ADDR_RD issues a memory read in the same cycle. The registered byte is loaded into the tx shift register before the next fall, which is guaranteed by the SCK_MIN_DIV constraint. Then → READ.
    - ADDR_WR → WRITE.
  - READ:
    - miso_oe_o=1 from the first fall after the address.
    - Each fall drives tx[7] and shifts left.
    - After 8 bits: addr+1, fetch next byte, reload on the following fall (seamless sequential burst).
  - WRITE:
    - Shift mosi on rise.
    - On the 8th rise: mem[addr] ← byte (1-cycle write), addr+1, counter=0.
  - IGNORE: no memory access, miso_oe_o=0, wait for cs_q high.
- Address wrap: addr increments modulo 2**ADDR_WIDTH, so 0x3FF → 0x000 at the default width.
- Simultaneous CS deassert and 8th write rise: CS wins and no write occurs, because edges are qualified by cs_q low.
- sck_q high when CS asserts: no false rise is generated, since the edge detector tracks sck continuously.
- miso_o holds its last value when miso_oe_o=0; the bench checks it only while oe=1.
- Latency: write commits 1 clk after the 8th data rise; read data bit 7 appears 1 clk after the first fall following the last address bit, plus sync delay.

Optional Feature:
- Macro SPI_TARGET_SYNC_EN.
- Defined: sck_i, cs_ni, mosi_i each pass through a 2-flop synchroniser before edge detection (+2 clk latency); supports asynchronous initiators with sck period ≥ 8 clk_i.
- Undefined: inputs are registered once only (same clock domain as the initiator); sck period ≥ 4 clk_i.

Test Plan:
- Write 0x02, addr 0x000010, data 0xA5 → mem[0x010]=0xA5, cmd_err_o never pulses, busy_o falls within 3 clk of cs_ni high.
- Read 0x03, addr 0x000010 after the previous write → miso returns 0xA5 MSB-first, miso_oe_o high only during the data phase.
- Sequential burst: write 0x11,0x22,0x33 at addr 0x0003FE, then read 3 bytes from 0x0003FE → 0x11,0x22,0x33 with mem[0x000]=0x33 (wrap).
- Command 0x9F → cmd_err_o single pulse after the 8th bit, miso_oe_o stays 0, no memory change; the next transaction works normally.
- Write with cs_ni raised after 5 data bits to addr 0x20 (preloaded 0x5A) → mem[0x20] stays 0x5A.
- rst_ni low mid-read burst → miso_oe_o=0 and busy_o=0 next clk; the following read of 0x010 returns 0xA5 (memory retained).
